// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: stall-vector mode (bubble/hold from the global
// stall vector) or elastic valid/ready mode with a 2-entry skid, plus bubble counter.
module pipe_stage_reg #(
  parameter int                 DATA_W  = 32+5+1,
  parameter int                 STALL_W = 6,
  parameter int                 STAGE   = 3,
  parameter int                 MODE    = 0,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic bub_evt;

  // Each mode ignores part of the inputs; fold them here so nothing dangles.
  logic unused_ok;
  assign unused_ok = ^{stall, out_ready};

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (bub_evt && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  if (MODE == 0) begin : g_stall
    logic stall_here, stall_next;
    assign stall_here = stall[STAGE];
    assign stall_next = stall[STAGE+1];
    assign in_ready   = !rst && !stall_here;
    assign bub_evt    = flush || (stall_here && !stall_next);

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        out_valid <= 1'b0;
        out_data  <= NOP_VAL;
      end else if (!stall_here) begin
        out_valid <= in_valid;
        out_data  <= in_valid ? in_data : NOP_VAL;
      end else if (!stall_next) begin
        out_valid <= 1'b0;
        out_data  <= NOP_VAL;
      end
    end
  end else begin : g_elastic
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
    state_t            state;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              push, pop;

    // in_ready comes from registered state only, so no path from out_ready.
    assign in_ready  = !rst && (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign bub_evt   = flush || (out_ready && !out_valid);

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state  <= S_EMPTY;
        main_q <= NOP_VAL;
        skid_q <= NOP_VAL;
      end else begin
        case (state)
          S_EMPTY: if (push) begin
            main_q <= in_data;
            state  <= S_ONE;
          end
          S_ONE: begin
            if (push && pop) begin
              main_q <= in_data;
            end else if (push) begin
              skid_q <= in_data;
              state  <= S_TWO;
            end else if (pop) begin
              main_q <= NOP_VAL;
              state  <= S_EMPTY;
            end
          end
          S_TWO: if (pop) begin
            main_q <= skid_q;
            skid_q <= NOP_VAL;
            state  <= S_ONE;
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: stall-mode instance, a CNT_W=2 stall-mode twin for saturation,
// and an elastic-mode instance, each checked against hand-computed values.
module tb_pipe_stage_reg;
  localparam logic [7:0] NOP = 8'hEE;

  logic       clk = 0;
  logic       rst = 1;
  logic       flush0 = 0, flush1 = 0;
  logic [5:0] stall = '0, stall1 = '0;
  logic       in_valid = 0, in_valid1 = 0;
  logic [7:0] in_data = '0, in_data1 = '0;
  logic       out_ready0 = 0, out_ready1 = 0;

  logic        rdy0, vld0, rdy2, vld2, rdy1, vld1;
  logic [7:0]  dat0, dat2, dat1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .STALL_W(6), .STAGE(3), .MODE(0), .NOP_VAL(NOP), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .stall(stall), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(vld0), .out_ready(out_ready0), .out_data(dat0), .bubble_cnt(cnt0));

  pipe_stage_reg #(.DATA_W(8), .STALL_W(6), .STAGE(3), .MODE(0), .NOP_VAL(NOP), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush0), .stall(stall), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(vld2), .out_ready(out_ready0), .out_data(dat2), .bubble_cnt(cnt2));

  pipe_stage_reg #(.DATA_W(8), .STALL_W(6), .STAGE(3), .MODE(1), .NOP_VAL(NOP), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .stall(stall1), .in_valid(in_valid1), .in_ready(rdy1),
    .in_data(in_data1), .out_valid(vld1), .out_ready(out_ready1), .out_data(dat1), .bubble_cnt(cnt1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int errs, pops;
    logic [15:0] cnt_base;

    // reset
    #1;
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    step(); step();
    chk("rst_vld0", vld0, 0);
    chk("rst_dat0", dat0, NOP);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_dat1", dat1, NOP);
    rst = 0;

    // stall mode: plain load
    in_valid = 1; in_data = 8'hA5; #1;
    chk("m0_rdy", rdy0, 1);
    step();
    chk("m0_ld_vld", vld0, 1);
    chk("m0_ld_dat", dat0, 8'hA5);
    chk("m0_ld_cnt", cnt0, 0);

    // own stage stalled, next free -> bubble
    stall = 6'b001000; in_data = 8'h77; #1;
    chk("m0_stall_rdy", rdy0, 0);
    step();
    chk("m0_bub_vld", vld0, 0);
    chk("m0_bub_dat", dat0, NOP);
    chk("m0_bub_cnt", cnt0, 1);

    stall = '0; in_data = 8'h55;
    step();
    chk("m0_ld55", dat0, 8'h55);

    // both stalled -> hold
    stall = 6'b011000; in_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m0_hold_dat", dat0, 8'h55);
      chk("m0_hold_vld", vld0, 1);
      chk("m0_hold_cnt", cnt0, 1);
    end

    // flush overrides hold
    flush0 = 1;
    step();
    flush0 = 0;
    chk("m0_fl_vld", vld0, 0);
    chk("m0_fl_dat", dat0, NOP);
    chk("m0_fl_cnt", cnt0, 2);
    chk("m0_fl_cnt2", cnt2, 2);

    // unstalled with in_valid=0 loads a NOP
    stall = '0; in_valid = 0; in_data = 8'h12;
    step();
    chk("m0_nv_vld", vld0, 0);
    chk("m0_nv_dat", dat0, NOP);
    chk("m0_nv_cnt", cnt0, 2);

    // saturation on the 2-bit twin
    stall = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m0_sat_cnt16", cnt0, 3 + i);
      chk("m0_sat_cnt2", cnt2, 3);
    end
    stall = '0;

    // elastic mode: idle so far with out_ready=0, no bubbles
    chk("m1_idle_cnt", cnt1, 0);
    in_valid1 = 1; in_data1 = 8'h01; #1;
    chk("m1_rdy0", rdy1, 1);
    step();
    chk("m1_p1_vld", vld1, 1);
    chk("m1_p1_dat", dat1, 8'h01);
    chk("m1_p1_rdy", rdy1, 1);
    in_data1 = 8'h02;
    step();
    chk("m1_p2_rdy", rdy1, 0);
    chk("m1_p2_dat", dat1, 8'h01);
    in_data1 = 8'h03;
    step();
    chk("m1_p3_rdy", rdy1, 0);
    chk("m1_p3_dat", dat1, 8'h01);
    out_ready1 = 1;
    step();
    chk("m1_d2_dat", dat1, 8'h02);
    chk("m1_d2_rdy", rdy1, 1);
    step();
    chk("m1_d3_dat", dat1, 8'h03);
    in_valid1 = 0;
    step();
    chk("m1_empty_vld", vld1, 0);
    chk("m1_empty_dat", dat1, NOP);
    chk("m1_empty_cnt", cnt1, 0);
    step();
    chk("m1_bub_cnt", cnt1, 1);

    // flush with one entry held
    out_ready1 = 0; in_valid1 = 1; in_data1 = 8'hAA;
    step();
    chk("m1_aa_dat", dat1, 8'hAA);
    in_valid1 = 0; flush1 = 1;
    step();
    flush1 = 0;
    chk("m1_fl_vld", vld1, 0);
    chk("m1_fl_dat", dat1, NOP);
    chk("m1_fl_cnt", cnt1, 2);
    chk("m1_fl_rdy", rdy1, 1);

    // sustained streaming
    cnt_base = cnt1;
    errs = 0; pops = 0;
    in_valid1 = 1; out_ready1 = 1;
    for (int i = 0; i < 100; i++) begin
      in_data1 = 8'(i);
      #1;
      if (rdy1 !== 1'b1) errs++;
      if (vld1 === 1'b1) pops++;
      step();
      if (vld1 !== 1'b1 || dat1 !== 8'(i)) errs++;
    end
    in_valid1 = 0;
    if (vld1 === 1'b1) pops++;
    step();
    chk("m1_stream_errs", errs, 0);
    chk("m1_stream_pops", pops, 100);
    chk("m1_stream_cnt", cnt1, cnt_base + 16'd1);
    chk("m1_stream_end", vld1, 0);

    // rst mid-stream: everything cleared
    in_valid1 = 1; in_data1 = 8'h5A; out_ready1 = 0;
    step();
    rst = 1; #1;
    chk("rst2_rdy0", rdy0, 0);
    chk("rst2_rdy1", rdy1, 0);
    step();
    chk("rst2_cnt0", cnt0, 0);
    chk("rst2_cnt2", cnt2, 0);
    chk("rst2_cnt1", cnt1, 0);
    chk("rst2_vld0", vld0, 0);
    chk("rst2_vld1", vld1, 0);
    chk("rst2_dat1", dat1, NOP);
    rst = 0; in_valid1 = 0;
    #1;
    chk("rst2_rel_rdy1", rdy1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
